stream_mux_n: RTL and testbench
===============================

STREAM_MUX_N -- requirements
Module: stream_mux_n

Interface
REQ-001 Parameter CH, default 4, number of input channels (2..16).
REQ-002 Parameter W, default 8, data width per channel (1..64).
REQ-003 Parameter MODE, default 0, arbitration mode: 0 = external select, 1 = round-robin.
REQ-004 Localparam SW = $clog2(CH), select/channel-index width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_data  input  CH*W  packed channel data; channel i occupies bits [i*W +: W].
REQ-008 in_valid  input  CH  per-channel valid.
REQ-009 in_ready  output  CH  per-channel ready; at most one bit high.
REQ-010 sel  input  SW  channel select, used only when MODE=0.
REQ-011 out_data  output  W  registered selected data.
REQ-012 out_chan  output  SW  index of the channel that supplied out_data.
REQ-013 out_valid  output  1  out_data/out_chan hold a beat.
REQ-014 out_ready  input  1  downstream accepts beat when high with out_valid.

Function
REQ-015 load = !out_valid || out_ready; the output register accepts a new beat only when load=1.
REQ-016 MODE=0: grant = sel when sel<CH and in_valid[sel]=1; otherwise no grant.
REQ-017 MODE=1: grant = first channel with in_valid high, searching ptr+1, ptr+2, ... modulo CH; no grant if none valid.
REQ-018 in_ready[g] = load for the granted channel g; all other in_ready bits 0; in_ready is combinational from in_valid, sel, ptr, out_valid, out_ready.
REQ-019 Transfer in: on edge with in_valid[g] && in_ready[g], out_data <= channel g data, out_chan <= g, out_valid <= 1.
REQ-020 On edge with out_valid && out_ready and no transfer in, out_valid <= 0; out_data and out_chan hold their values.
REQ-021 Simultaneous output drain and input transfer: register reloads in the same cycle, out_valid stays 1; sustained throughput one beat per clock.
REQ-022 Latency: accepted input beat appears on out_data exactly one clock later.
REQ-023 Stall: out_valid=1 and out_ready=0 -> all in_ready 0, output register unchanged.
REQ-024 MODE=1: ptr <= g only on a transfer in; ptr unchanged when no transfer, giving fair rotation with wrap from CH-1 to 0.
REQ-025 MODE=0: ptr unused, held at reset value.
REQ-026 sel changes while stalled are permitted; grant re-evaluates each cycle with no memory of prior sel.

Reset
REQ-027 rst_n low asynchronously forces out_valid=0, out_data=0, out_chan=0, ptr=CH-1 (channel 0 highest priority after reset).
REQ-028 in_ready SHALL be all 0 while rst_n is low.
REQ-029 Reset asserted mid-stream discards the registered beat; no beat is accepted on the edge where rst_n is released... first transfer possible on the following edge.

Configuration
REQ-030 Macro STREAM_MUX_CNT_EN defined: adds output beat_cnt (16 bits), incremented on each out_valid && out_ready, wraps 0xFFFF -> 0x0000, reset to 0.
REQ-031 Macro STREAM_MUX_CNT_EN undefined: beat_cnt port and counter absent; all other behaviour identical.

Verification
REQ-032 MODE=0, CH=4, W=8, sel=2, in_data ch2=0xA5, in_valid=0100, out_ready=1 -> in_ready=0100, next cycle out_data=0xA5, out_chan=2, out_valid=1.
REQ-033 MODE=1, all four in_valid=1 for 8 cycles, out_ready=1 -> out_chan sequence 0,1,2,3,0,1,2,3, one beat per clock.
REQ-034 MODE=1, in_valid=1010, out_ready=1 -> grants alternate 1,3,1,3; ch0/ch2 never granted.
REQ-035 Output stall: out_valid=1 with 0x3C, out_ready=0 for 3 cycles while in_valid=1111 -> in_ready=0000, out_data stays 0x3C, then out_ready=1 -> next beat loaded same edge.
REQ-036 rst_n pulled low mid-stream with out_valid=1 -> out_valid=0, out_data=0 immediately (before next edge); after release MODE=1 grants channel 0 first.
REQ-037 STREAM_MUX_CNT_EN defined: 0x10000 accepted beats -> beat_cnt returns to 0x0000; with 5 stalled cycles counted beats unchanged.

Source files
------------

// File: rtl/stream_mux_n.sv
// -----------------------------------------------------------------------------
// stream_mux_n
//
// Purpose
//   N-to-1 valid/ready stream multiplexer with a single registered output
//   stage. One input channel per cycle may be granted, either by an external
//   select (MODE=0) or by a round-robin pointer (MODE=1). The output register
//   reloads on the same edge it drains, so a continuous stream moves at one
//   beat per clock with one clock of latency.
//
// Parameters
//   CH    number of input channels (2..16)
//   W     data width per channel (1..64)
//   MODE  0 = external select via sel, 1 = round-robin
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    CH*W packed channel data, channel i at [i*W +: W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit high (combinational)
//   sel        channel select, only used when MODE=0
//   out_data   registered data of the accepted beat
//   out_chan   index of the channel that supplied out_data
//   out_valid  out_data/out_chan hold a beat
//   out_ready  downstream accepts the beat when high together with out_valid
//   beat_cnt   (only with STREAM_MUX_CNT_EN) 16-bit wrapping count of beats
//              delivered downstream
//
// Build options
//   STREAM_MUX_CNT_EN  define to add the beat_cnt output and its counter.
// -----------------------------------------------------------------------------
module stream_mux_n #(
  parameter int CH   = 4,
  parameter int W    = 8,
  parameter int MODE = 0,
  localparam int SW  = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*W-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  input  logic [SW-1:0]   sel,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_chan,
  output logic            out_valid,
  input  logic            out_ready
`ifdef STREAM_MUX_CNT_EN
  ,
  output logic [15:0]     beat_cnt
`endif
);

  // Output register and round-robin pointer
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_chan_q,  out_chan_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  // Cleared by reset and set on the first edge after release, so the edge on
  // which rst_n deasserts can never accept a beat.
  logic          en_q;

  // Arbitration results
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  grant_data;
  logic          load;
  logic          take;

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [SW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (MODE == 0) begin
      // Only an in-range select naming a valid channel produces a grant.
      for (int i = 0; i < CH; i++) begin
        if (sel == SW'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(i);
        end
      end
    end else begin
      // Walk the search order ptr+CH .. ptr+1 backwards: the last match
      // written is the earliest channel after ptr, which is the winner.
      for (int k = CH; k >= 1; k--) begin
        cand = SW'((int'(ptr_q) + k) % CH);
        if (in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant_idx == SW'(i)) begin
        grant_data = in_data[i*W +: W];
      end
    end
  end

  // The output stage can take a beat when empty or when it drains this edge.
  assign load = !out_valid_q || out_ready;
  assign take = en_q && grant_vld && load;

  always_comb begin
    in_ready = '0;
    if (take) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
    end else if (out_valid_q && out_ready) begin
      // Drain without refill: data/chan keep their last values.
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    // In select mode the pointer is never moved from its reset value.
    if (MODE == 1 && take) begin
      ptr_d = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      // CH-1 makes channel 0 the first candidate after reset.
      ptr_q       <= SW'(CH - 1);
      en_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
      en_q        <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

`ifdef STREAM_MUX_CNT_EN
  // ---------------------------------------------------------------------------
  // Delivered-beat counter, wraps naturally at 16 bits
  // ---------------------------------------------------------------------------
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q && out_ready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux_n.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_n
//
// Bench for stream_mux_n. Two instances share clock and reset: u0 in select
// mode (MODE=0) and u1 in round-robin mode (MODE=1), both CH=4, W=8. A
// behavioural model tracks the expected contents of each output stage and
// is compared every cycle; table vectors and hand sequences add fixed
// expectations for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_stream_mux_n;

  logic        clk;
  logic        rst_n;

  logic [3:0]  iv   [2];
  logic [31:0] idat [2];
  logic [1:0]  sl   [2];
  logic        ordy [2];

  logic [3:0]  ir   [2];
  logic [7:0]  od   [2];
  logic [1:0]  oc   [2];
  logic        ov   [2];
`ifdef STREAM_MUX_CNT_EN
  logic [15:0] bc   [2];
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model state per instance
  bit       mv   [2];
  bit [7:0] md   [2];
  int       mc   [2];
  int       mptr [2];
  bit       men  [2];
  int       mcnt [2];

  stream_mux_n #(.CH(4), .W(8), .MODE(0)) u0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (idat[0]),
    .in_valid  (iv[0]),
    .in_ready  (ir[0]),
    .sel       (sl[0]),
    .out_data  (od[0]),
    .out_chan  (oc[0]),
    .out_valid (ov[0]),
    .out_ready (ordy[0])
`ifdef STREAM_MUX_CNT_EN
    ,
    .beat_cnt  (bc[0])
`endif
  );

  stream_mux_n #(.CH(4), .W(8), .MODE(1)) u1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (idat[1]),
    .in_valid  (iv[1]),
    .in_ready  (ir[1]),
    .sel       (sl[1]),
    .out_data  (od[1]),
    .out_chan  (oc[1]),
    .out_valid (ov[1]),
    .out_ready (ordy[1])
`ifdef STREAM_MUX_CNT_EN
    ,
    .beat_cnt  (bc[1])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Which channel the rules say should win right now (-1 = none).
  function automatic int mgrant(input int m);
    if (m == 0) begin
      if (int'(sl[0]) < 4 && iv[0][sl[0]]) return int'(sl[0]);
      return -1;
    end
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (mptr[1] + k) % 4;
      if (iv[1][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] mready(input int m);
    int g;
    if (!rst_n || !men[m]) return 4'b0000;
    if (mv[m] && !ordy[m]) return 4'b0000;
    g = mgrant(m);
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; md[m] = 8'h00; mc[m] = 0; mptr[m] = 3; men[m] = 0; mcnt[m] = 0;
    end
  endfunction

  // Apply one rising edge to the model, using the inputs present at the edge.
  function automatic void model_edge();
    for (int m = 0; m < 2; m++) begin
      logic [3:0] r;
      int g;
      if (!rst_n) continue;
      r = mready(m);
      g = mgrant(m);
      if (mv[m] && ordy[m]) mcnt[m] = (mcnt[m] + 1) % 65536;
      if (r != 4'b0000) begin
        md[m] = idat[m][g*8 +: 8];
        mc[m] = g;
        mv[m] = 1;
        if (m == 1) mptr[m] = g;
      end else if (mv[m] && ordy[m]) begin
        mv[m] = 0;
      end
      men[m] = 1;
    end
  endfunction

  // Inputs are driven just after a rising edge; this checks the combinational
  // ready, advances through the next edge and checks the registered outputs.
  task automatic cycle();
    #1;
    for (int m = 0; m < 2; m++) chk($sformatf("in_ready%0d", m), 32'(ir[m]), 32'(mready(m)));
    @(posedge clk);
    model_edge();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("out_valid%0d", m), 32'(ov[m]), 32'(mv[m]));
      chk($sformatf("out_data%0d", m),  32'(od[m]), 32'(md[m]));
      chk($sformatf("out_chan%0d", m),  32'(oc[m]), 32'(mc[m]));
`ifdef STREAM_MUX_CNT_EN
      chk($sformatf("beat_cnt%0d", m),  32'(bc[m]), 32'(mcnt[m]));
`endif
    end
  endtask

  typedef struct packed {
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] rdy;
    logic       v;
    logic [1:0] ch;
    logic [7:0] d;
  } vec_t;

  vec_t tbl [13];

  initial begin
`ifdef STREAM_MUX_CNT_EN
    logic [15:0] c0;
`endif
    // Round-robin vectors for u1, starting from reset (ptr=3, empty output).
    // Channel i carries data 0x10+i.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[8]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[9]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[10] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[11] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h13};

    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      iv[m] = 4'b0000; idat[m] = 32'h0; sl[m] = 2'd0; ordy[m] = 1'b1;
    end
    model_reset();
    #12;
    for (int m = 0; m < 2; m++) begin
      chk("reset out_valid", 32'(ov[m]), 32'd0);
      chk("reset out_data",  32'(od[m]), 32'd0);
      chk("reset out_chan",  32'(oc[m]), 32'd0);
      chk("reset in_ready",  32'(ir[m]), 32'd0);
    end

    // Release mid-cycle, then one idle edge.
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Table-driven round-robin sequence
    idat[1] = 32'h13121110;
    for (int i = 0; i < 13; i++) begin
      iv[1] = tbl[i].iv; ordy[1] = tbl[i].ordy;
      iv[0] = tbl[i].iv; ordy[0] = 1'b1; sl[0] = 2'd0;
      #1;
      chk($sformatf("tbl%0d in_ready", i), 32'(ir[1]), 32'(tbl[i].rdy));
      cycle();
      chk($sformatf("tbl%0d out_valid", i), 32'(ov[1]), 32'(tbl[i].v));
      chk($sformatf("tbl%0d out_chan", i),  32'(oc[1]), 32'(tbl[i].ch));
      chk($sformatf("tbl%0d out_data", i),  32'(od[1]), 32'(tbl[i].d));
    end

    // Select mode: channel 2 with 0xA5
    sl[0] = 2'd2; idat[0] = 32'h00A50000; iv[0] = 4'b0100; ordy[0] = 1'b1;
    #1;
    chk("sel2 in_ready", 32'(ir[0]), 32'h4);
    cycle();
    chk("sel2 out_data",  32'(od[0]), 32'hA5);
    chk("sel2 out_chan",  32'(oc[0]), 32'd2);
    chk("sel2 out_valid", 32'(ov[0]), 32'd1);

    // Stall: hold 0x3C for 5 cycles while sel wanders, then refill on drain
    sl[0] = 2'd1; idat[0] = 32'h00003C00; iv[0] = 4'b1111; ordy[0] = 1'b1;
    cycle();
    chk("stall load", 32'(od[0]), 32'h3C);
`ifdef STREAM_MUX_CNT_EN
    c0 = bc[0];
`endif
    ordy[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sl[0] = 2'(i); idat[0] = $urandom;
      #1;
      chk("stall in_ready", 32'(ir[0]), 32'h0);
      cycle();
      chk("stall out_data",  32'(od[0]), 32'h3C);
      chk("stall out_valid", 32'(ov[0]), 32'd1);
    end
`ifdef STREAM_MUX_CNT_EN
    chk("stall beat_cnt", 32'(bc[0]), 32'(c0));
`endif
    ordy[0] = 1'b1; sl[0] = 2'd2; idat[0] = 32'h00770000;
    #1;
    chk("unstall in_ready", 32'(ir[0]), 32'h4);
    cycle();
    chk("unstall out_data",  32'(od[0]), 32'h77);
    chk("unstall out_chan",  32'(oc[0]), 32'd2);
    chk("unstall out_valid", 32'(ov[0]), 32'd1);

    // Reset mid-stream on round-robin instance
    iv[1] = 4'b1111; ordy[1] = 1'b1;
    cycle();
    cycle();
    chk("pre-reset out_valid", 32'(ov[1]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async reset out_valid", 32'(ov[1]), 32'd0);
    chk("async reset out_data",  32'(od[1]), 32'd0);
    chk("async reset in_ready1", 32'(ir[1]), 32'd0);
    chk("async reset in_ready0", 32'(ir[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release edge in_ready", 32'(ir[1]), 32'd0);
    cycle();
    chk("release edge out_valid", 32'(ov[1]), 32'd0);
    #1;
    chk("first grant in_ready", 32'(ir[1]), 32'h1);
    cycle();
    chk("first grant out_chan",  32'(oc[1]), 32'd0);
    chk("first grant out_valid", 32'(ov[1]), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int m = 0; m < 2; m++) begin
        iv[m]   = 4'($urandom);
        sl[m]   = 2'($urandom);
        idat[m] = $urandom;
        ordy[m] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end

`ifdef STREAM_MUX_CNT_EN
    // 0x10000 delivered beats bring the counter back to where it started
    iv[1] = 4'b1111; ordy[1] = 1'b1; iv[0] = 4'b0000; ordy[0] = 1'b1;
    cycle();
    c0 = bc[1];
    for (int n = 0; n < 65536; n++) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    chk("wrap beat_cnt", 32'(bc[1]), 32'(c0));
    chk("wrap beat_cnt model", 32'(bc[1]), 32'(mcnt[1]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
